// File: rtl/mem_wb_stage.sv
// Purpose : MEM stage of the 5-stage MIPS core. It handles data-memory word/byte
//           access, selects the write-back value, registers MEM/WB, and runs the
//           syscall halt FSM and the retired-instruction counter.
// Latency : 1 cycle from the EX/MEM fields to the MEM/WB outputs.
//           Loads read memory combinationally before that edge's write.
// Backpressure: run=0, or halt=1, freezes all state including memory.
//           The HALT state is left only through rst_n.
// Ports   : clk, rst_n (async active-low), run, clear;
//           EX/MEM fields WE, Byte, WE_DM, set, sys, lower, data_in_re_choose,
//           RW, PC, result, RFD2, LO;
//           outputs WE_wb, RW_wb, wdata_wb, halt, retired.
module mem_wb_stage #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              clear,
  input  logic              WE,
  input  logic              Byte,
  input  logic              WE_DM,
  input  logic              set,
  input  logic              sys,
  input  logic              lower,
  input  logic [1:0]        data_in_re_choose,
  input  logic [4:0]        RW,
  input  logic [31:0]       PC,
  input  logic [31:0]       result,
  input  logic [31:0]       RFD2,
  input  logic [31:0]       LO,
  output logic              WE_wb,
  output logic [4:0]        RW_wb,
  output logic [31:0]       wdata_wb,
  output logic              halt,
  output logic [31:0]       retired
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t state, state_nxt;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  logic              en;       // the stage is allowed to advance this edge
  logic              valid;    // a real, unflushed instruction occupies MEM
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic [31:0]       ld_word;
  logic [7:0]        ld_byte;
  logic [31:0]       ld_data;
  logic [31:0]       wb_sel;

  assign en    = run && (state == RUN);
  assign valid = lower && !clear;
  assign idx   = result[ADDR_W+1:2];
  assign lane  = result[1:0];

  // Data memory. It has no reset, so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (en && valid && WE_DM) begin
      if (Byte) mem[idx][{lane, 3'b000} +: 8] <= RFD2[7:0];
      else      mem[idx] <= RFD2;
    end
  end

  // Load path. Lane 0 is the least-significant byte (little-endian).
  always_comb begin
    ld_word = mem[idx];
    ld_byte = 8'h00;
    case (lane)
      2'd0: ld_byte = ld_word[7:0];
      2'd1: ld_byte = ld_word[15:8];
      2'd2: ld_byte = ld_word[23:16];
      2'd3: ld_byte = ld_word[31:24];
      default: ld_byte = 8'h00;
    endcase
    if (Byte) ld_data = {{24{set & ld_byte[7]}}, ld_byte};
    else      ld_data = ld_word;
  end

  always_comb begin
    wb_sel = result;
    case (data_in_re_choose)
      2'd0: wb_sel = result;
      2'd1: wb_sel = ld_data;
      2'd2: wb_sel = PC + 32'd4;
      2'd3: wb_sel = LO;
      default: wb_sel = result;
    endcase
  end

  // MEM/WB register. A syscall never writes the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WE_wb    <= 1'b0;
      RW_wb    <= 5'd0;
      wdata_wb <= 32'd0;
    end else if (en) begin
      if (clear) begin
        WE_wb    <= 1'b0;
        RW_wb    <= 5'd0;
        wdata_wb <= 32'd0;
      end else begin
        WE_wb    <= WE & lower & ~sys;
        RW_wb    <= RW;
        wdata_wb <= wb_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             retired <= 32'd0;
    else if (en && valid)   retired <= retired + 32'd1;
  end

  // Halt FSM: state register / next state / outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == RUN && run && valid && sys) state_nxt = HALT;
  end

  always_comb begin
    halt = (state == HALT);
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Purpose : directed self-checking bench for mem_wb_stage.
// Latency : outputs are sampled 1 ns after each rising edge.
// Backpressure: exercises run=0 stalls, clear flushes and the halt freeze.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, clear, WE, Byte, WE_DM, set, sys, lower;
  logic [1:0]  data_in_re_choose;
  logic [4:0]  RW;
  logic [31:0] PC, result, RFD2, LO;
  logic        WE_wb;
  logic [4:0]  RW_wb;
  logic [31:0] wdata_wb;
  logic        halt;
  logic [31:0] retired;

  int checks   = 0;
  int failures = 0;

  mem_wb_stage #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clear(clear), .WE(WE), .Byte(Byte),
    .WE_DM(WE_DM), .set(set), .sys(sys), .lower(lower),
    .data_in_re_choose(data_in_re_choose), .RW(RW), .PC(PC), .result(result),
    .RFD2(RFD2), .LO(LO), .WE_wb(WE_wb), .RW_wb(RW_wb), .wdata_wb(wdata_wb),
    .halt(halt), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    run = 1'b1; clear = 1'b0; WE = 1'b0; Byte = 1'b0; WE_DM = 1'b0; set = 1'b0;
    sys = 1'b0; lower = 1'b1; data_in_re_choose = 2'd0; RW = 5'd0;
    PC = 32'd0; result = 32'd0; RFD2 = 32'd0; LO = 32'd0;
  endtask

  initial begin
    idle();
    lower = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_we",      {31'd0, WE_wb}, 32'd0);
    chk("rst_rw",      {27'd0, RW_wb}, 32'd0);
    chk("rst_wdata",   wdata_wb, 32'd0);
    chk("rst_halt",    {31'd0, halt}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    #1 rst_n = 1'b1;

    // Word store 0xDEADBEEF to 0x10, then load it back.
    idle(); WE_DM = 1'b1; result = 32'h10; RFD2 = 32'hDEADBEEF;
    step();
    chk("st_we",      {31'd0, WE_wb}, 32'd0);
    chk("st_wdata",   wdata_wb, 32'h10);
    chk("st_retired", retired, 32'd1);
    idle(); WE = 1'b1; RW = 5'd8; data_in_re_choose = 2'd1; result = 32'h10;
    step();
    chk("ld_we",      {31'd0, WE_wb}, 32'd1);
    chk("ld_rw",      {27'd0, RW_wb}, 32'd8);
    chk("ld_wdata",   wdata_wb, 32'hDEADBEEF);
    chk("ld_retired", retired, 32'd2);

    // Byte store 0x80 to lane 3. Only RFD2[7:0] may land in memory.
    idle(); WE_DM = 1'b1; Byte = 1'b1; result = 32'h13; RFD2 = 32'h12345680;
    step();
    chk("bst_retired", retired, 32'd3);
    idle(); WE = 1'b1; RW = 5'd4; data_in_re_choose = 2'd1; result = 32'h10;
    step();
    chk("bst_word", wdata_wb, 32'h80ADBEEF);
    idle(); Byte = 1'b1; set = 1'b1; data_in_re_choose = 2'd1; result = 32'h13;
    step();
    chk("lb_sext", wdata_wb, 32'hFFFFFF80);
    idle(); Byte = 1'b1; set = 1'b0; data_in_re_choose = 2'd1; result = 32'h13;
    step();
    chk("lb_zext", wdata_wb, 32'h00000080);
    idle(); Byte = 1'b1; set = 1'b1; data_in_re_choose = 2'd1; result = 32'h11;
    step();
    chk("lb_lane1", wdata_wb, 32'hFFFFFFBE);
    chk("lb_retired", retired, 32'd7);

    // Write-back select: PC+4, PC+4 wrapping past 2^32, and LO.
    idle(); data_in_re_choose = 2'd2; PC = 32'h00003000;
    step();
    chk("sel_pc4", wdata_wb, 32'h00003004);
    idle(); data_in_re_choose = 2'd2; PC = 32'hFFFFFFFC;
    step();
    chk("sel_pc4_wrap", wdata_wb, 32'h00000000);
    idle(); data_in_re_choose = 2'd3; LO = 32'h12345678;
    step();
    chk("sel_lo", wdata_wb, 32'h12345678);
    chk("sel_retired", retired, 32'd10);

    // A flushed store must not reach memory or the counter.
    idle(); clear = 1'b1; WE = 1'b1; WE_DM = 1'b1; RW = 5'd5; result = 32'h10;
    RFD2 = 32'h11111111;
    step();
    chk("clr_we",      {31'd0, WE_wb}, 32'd0);
    chk("clr_rw",      {27'd0, RW_wb}, 32'd0);
    chk("clr_wdata",   wdata_wb, 32'd0);
    chk("clr_retired", retired, 32'd10);
    idle(); WE = 1'b1; RW = 5'd3; data_in_re_choose = 2'd1; result = 32'h10;
    step();
    chk("clr_mem", wdata_wb, 32'h80ADBEEF);
    chk("clr_ld_retired", retired, 32'd11);

    // Stall for 3 cycles while a store is presented. Nothing may move.
    idle(); run = 1'b0; WE_DM = 1'b1; WE = 1'b0; RW = 5'd9; result = 32'h10;
    RFD2 = 32'h55555555; sys = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_we",      {31'd0, WE_wb}, 32'd1);
      chk("stall_rw",      {27'd0, RW_wb}, 32'd3);
      chk("stall_wdata",   wdata_wb, 32'h80ADBEEF);
      chk("stall_retired", retired, 32'd11);
      chk("stall_halt",    {31'd0, halt}, 32'd0);
    end
    idle(); data_in_re_choose = 2'd1; result = 32'h10;
    step();
    chk("stall_mem", wdata_wb, 32'h80ADBEEF);

    // A bubble must not write the register file or count as retired.
    idle(); lower = 1'b0; WE = 1'b1; RW = 5'd7; result = 32'h44;
    step();
    chk("bub_we",      {31'd0, WE_wb}, 32'd0);
    chk("bub_rw",      {27'd0, RW_wb}, 32'd7);
    chk("bub_wdata",   wdata_wb, 32'h44);
    chk("bub_retired", retired, 32'd12);

    // When sys and clear coincide, clear wins.
    idle(); sys = 1'b1; clear = 1'b1;
    step();
    chk("sysclr_halt",    {31'd0, halt}, 32'd0);
    chk("sysclr_retired", retired, 32'd12);

    // Store to 0x20, then read it back through an aliased address.
    idle(); WE_DM = 1'b1; result = 32'h20; RFD2 = 32'hCAFEF00D;
    step();
    idle(); data_in_re_choose = 2'd1; result = 32'h1020;
    step();
    chk("wrap_ld", wdata_wb, 32'hCAFEF00D);
    chk("wrap_retired", retired, 32'd14);

    // Syscall: it counts as retired, never writes back, and halts the stage.
    idle(); sys = 1'b1; WE = 1'b1; RW = 5'd2; result = 32'h99;
    step();
    chk("sys_halt",    {31'd0, halt}, 32'd1);
    chk("sys_retired", retired, 32'd15);
    chk("sys_we",      {31'd0, WE_wb}, 32'd0);
    chk("sys_rw",      {27'd0, RW_wb}, 32'd2);
    chk("sys_wdata",   wdata_wb, 32'h99);

    // While halted, both the store and the outputs stay frozen.
    idle(); WE_DM = 1'b1; WE = 1'b1; RW = 5'd9; result = 32'h20; RFD2 = 32'h0;
    step();
    step();
    chk("hlt_halt",    {31'd0, halt}, 32'd1);
    chk("hlt_retired", retired, 32'd15);
    chk("hlt_rw",      {27'd0, RW_wb}, 32'd2);
    chk("hlt_we",      {31'd0, WE_wb}, 32'd0);

    // Assert reset between edges. The outputs must clear at once.
    idle(); lower = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_halt",    {31'd0, halt}, 32'd0);
    chk("arst_retired", retired, 32'd0);
    chk("arst_we",      {31'd0, WE_wb}, 32'd0);
    chk("arst_wdata",   wdata_wb, 32'd0);
    #1 rst_n = 1'b1;

    // Memory survives reset, and the halted store was dropped.
    idle(); data_in_re_choose = 2'd1; result = 32'h20;
    step();
    chk("post_rst_ld20", wdata_wb, 32'hCAFEF00D);
    idle(); data_in_re_choose = 2'd1; result = 32'h10;
    step();
    chk("post_rst_ld10", wdata_wb, 32'h80ADBEEF);
    chk("post_rst_retired", retired, 32'd2);
    chk("post_rst_halt", {31'd0, halt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM pipeline register in the 5-stage MIPS core.
- Takes the registered EX/MEM fields and performs the data-memory access: word/byte store, word/byte load.
- Selects the write-back value and drives the MEM/WB register toward the register file.
- Also owns the syscall halt state machine and a retired-instruction counter.

Parameters:
- ADDR_W, 10, word-address width; the data memory holds 2^ADDR_W 32-bit words.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  pipeline enable; 0 freezes all state
- clear  in  1  synchronous flush of the MEM/WB register when run=1
- WE  in  1  register-file write enable from EX/MEM
- Byte  in  1  1 = byte access, 0 = word access
- WE_DM  in  1  data-memory write enable
- set  in  1  byte load sign-extends when 1, zero-extends when 0
- sys  in  1  syscall in MEM
- lower  in  1  valid-instruction flag; 0 = bubble
- data_in_re_choose  in  2  write-back source select
- RW  in  5  destination register
- PC  in  32  instruction address
- result  in  32  ALU result / byte address
- RFD2  in  32  store data
- LO  in  32  LO register value
- WE_wb  out  1  MEM/WB register-file write enable
- RW_wb  out  5  MEM/WB destination register
- wdata_wb  out  32  MEM/WB write-back data
- halt  out  1  core halted
- retired  out  32  count of valid instructions passed to WB

Behaviour:
- Reset (rst_n=0, async): WE_wb=0, RW_wb=0, wdata_wb=0, halt=0, retired=0, FSM=RUN. Memory contents are not reset.
- Enable: all state updates only on the rising clk when run=1 and FSM=RUN. Once FSM=HALT, nothing updates, including memory, except via rst_n.
- Address: word index = result[ADDR_W+1:2]; lane = result[1:0]; upper bits are ignored, so addresses wrap modulo the memory size.
- Store, WE_DM=1, lower=1, clear=0, Byte=0: mem[idx] <= RFD2. Address bits [1:0] are ignored for word stores.
- Store, WE_DM=1, lower=1, clear=0, Byte=1: byte lane `lane` <= RFD2[7:0]; other lanes unchanged. Little-endian: lane 0 = bits [7:0].
- Load data is read combinationally from the current memory contents before the edge's write.
- Loads never follow a store to the same word in the same MEM cycle; the pipeline guarantees this.
- Byte load: lane extracted from the loaded word, then sign-extended if set=1, else zero-extended.
- Write-back source select:
  - data_in_re_choose 0 = result
  - 1 = load data
  - 2 = PC+4 (32-bit wrap)
  - 3 = LO
- MEM/WB register, 1-cycle latency: on the enabled edge, WE_wb <= WE & lower & ~clear; RW_wb <= RW; wdata_wb <= selected value.
- clear=1 forces WE_wb=0, RW_wb=0, wdata_wb=0 and suppresses the memory write and the counter increment.
- retired: +1 on an enabled edge with lower=1, clear=0. Wraps from 0xFFFFFFFF to 0.
- FSM RUN -> HALT on an enabled edge with sys=1, lower=1, clear=0:
  - That syscall counts as retired.
  - Its WE_wb is forced to 0.
  - halt=1 from the following cycle.
- FSM HALT -> RUN only via rst_n.
- run=0: all outputs and memory hold their values; the input fields are ignored.
- rst_n asserted mid-operation: outputs clear immediately, with no wait for clk. Memory retains its data.
- Simultaneous clear and sys: clear wins; no halt.

Test Plan:
- Word store then load: store RFD2=0xDEADBEEF to result=0x10; next cycle load result=0x10, choose=1, WE=1, RW=8 -> WE_wb=1, RW_wb=8, wdata_wb=0xDEADBEEF one cycle after the load's edge; retired=2.
- Byte store then load:
  - Byte store 0x80 to result=0x13 -> memory word at 0x10 = 0x80ADBEEF.
  - Byte load from 0x13 with set=1 -> wdata_wb=0xFFFFFF80.
  - Byte load from 0x13 with set=0 -> wdata_wb=0x00000080.
- Write-back select: PC=0x00003000, choose=2 -> wdata_wb=0x00003004; LO=0x12345678, choose=3 -> wdata_wb=0x12345678.
- Flush and stall:
  - clear=1 with WE=1, WE_DM=1 -> WE_wb=0, memory unchanged, retired unchanged.
  - run=0 for 3 cycles -> all outputs hold.
  - Bubble with lower=0 -> WE_wb=0, retired unchanged.
- Halt:
  - sys=1, lower=1 at retired=5 -> next cycle halt=1, retired=6, WE_wb=0.
  - Further stores are ignored.
  - sys=1 together with clear=1 -> halt stays 0.
- Async reset: drop rst_n between clock edges while halt=1 -> halt=0, retired=0, WE_wb=0 immediately.
- Async reset: previously stored data is still readable after rst_n releases.
